// File: rtl/sort_merge_pkg.sv
// Shared types and helpers for the two-run merge unit.
//   merge_state_t : FSM encoding (MERGE while both runs have quota left,
//                   DRAINx while only stream x still owes elements).
//   cnt_width()   : width of a per-stream counter that must hold 0..run_len.
package sort_merge_pkg;

  typedef enum logic [1:0] {
    MERGE  = 2'd0,
    DRAIN0 = 2'd1,
    DRAIN1 = 2'd2
  } merge_state_t;

  localparam int unsigned DEF_NBITS   = 8;
  localparam int unsigned DEF_RUN_LEN = 4;

  function automatic int unsigned cnt_width(input int unsigned run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/merge_out_buf.sv
// One-entry val/rdy pipeline register carrying {last, msg}.
//   enq_val/enq_rdy/enq_msg/enq_last : upstream side; enq_rdy is the
//                                      "space" signal (empty or draining).
//   deq_val/deq_rdy/deq_msg/deq_last : registered downstream side.
// A held entry stays unchanged until deq_rdy; a drain and a load can occur
// in the same cycle, so a continuous stream passes at one entry per cycle.
module merge_out_buf #(
  parameter int unsigned p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  input  logic               enq_last,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic               deq_last
);

  logic               val_q, val_d;
  logic [p_nbits-1:0] msg_q, msg_d;
  logic               last_q, last_d;

  always_comb begin
    enq_rdy = !val_q || deq_rdy;
    val_d   = val_q;
    msg_d   = msg_q;
    last_d  = last_q;
    if (enq_val && enq_rdy) begin
      val_d  = 1'b1;
      msg_d  = enq_msg;
      last_d = enq_last;
    end else if (deq_rdy) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= 1'b0;
      msg_q  <= '0;
      last_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      msg_q  <= msg_d;
      last_q <= last_d;
    end
  end

  assign deq_val  = val_q;
  assign deq_msg  = msg_q;
  assign deq_last = last_q;

endmodule

// File: rtl/sort_merge_unit.sv
// Merges two ascending runs of p_run_len elements (one per input stream)
// into one ascending run of 2*p_run_len elements, one element per cycle.
//   in0_*/in1_* : input streams; rdy means "popped this cycle".
//   out_*       : registered output stream; out_last flags the final
//                 element of each merged run.
// While both streams still owe elements the smaller head is taken (ties go
// to stream 0); once one stream has delivered its quota the other is drained.
module sort_merge_unit
  import sort_merge_pkg::*;
#(
  parameter int unsigned p_nbits   = DEF_NBITS,
  parameter int unsigned p_run_len = DEF_RUN_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_last
);

  localparam int unsigned CW = cnt_width(p_run_len);
  localparam logic [CW-1:0] RUN_LEN_C = CW'(p_run_len);
  // Combined count just before the final pop of a merged run.
  localparam logic [CW:0] LAST_TOTAL_C = (CW + 1)'(2 * p_run_len - 1);

  merge_state_t      state_q, state_d;
  logic [CW-1:0]     cnt0_q, cnt0_d;
  logic [CW-1:0]     cnt1_q, cnt1_d;

  logic              space;
  logic              take0;
  logic              pop;
  logic              last_pop;
  logic [CW:0]       popped_total;
  logic [p_nbits-1:0] sel_msg;

  always_comb begin
    in0_rdy = 1'b0;
    in1_rdy = 1'b0;
    take0   = (in0_msg <= in1_msg);

    case (state_q)
      // Never pop blind: both heads must be visible to pick the smaller.
      MERGE: begin
        if (in0_val && in1_val && space) begin
          in0_rdy = take0;
          in1_rdy = !take0;
        end
      end
      DRAIN0:  in0_rdy = in0_val && space;
      DRAIN1:  in1_rdy = in1_val && space;
      default: ;
    endcase

    pop          = in0_rdy || in1_rdy;
    sel_msg      = in0_rdy ? in0_msg : in1_msg;
    popped_total = {1'b0, cnt0_q} + {1'b0, cnt1_q};
    last_pop     = pop && (popped_total == LAST_TOTAL_C);

    cnt0_d  = cnt0_q + CW'(in0_rdy);
    cnt1_d  = cnt1_q + CW'(in1_rdy);
    state_d = state_q;

    if (last_pop) begin
      // Run complete: restart immediately so the next run has no bubble.
      cnt0_d  = '0;
      cnt1_d  = '0;
      state_d = MERGE;
    end else if (state_q == MERGE) begin
      if (cnt0_d == RUN_LEN_C) begin
        state_d = DRAIN1;
      end else if (cnt1_d == RUN_LEN_C) begin
        state_d = DRAIN0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MERGE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  merge_out_buf #(.p_nbits(p_nbits)) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (pop),
    .enq_rdy  (space),
    .enq_msg  (sel_msg),
    .enq_last (last_pop),
    .deq_val  (out_val),
    .deq_rdy  (out_rdy),
    .deq_msg  (out_msg),
    .deq_last (out_last)
  );

endmodule
